battle_link_ctl: RTL and testbench

BATTLE_LINK_CTL -- requirements
Module: battle_link_ctl

---
 rtl/battle_link_ctl.sv | 164 ++++++++++++++++
 tb/tb_battle_link_ctl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/battle_link_ctl.sv
// Link-cable frame controller: arbitrates KO/bomb/status/score requests and
// drives each winner as a strobed frame. Every output comes straight from a register.
module battle_link_ctl #(
  parameter int HOLD_CYC = 4,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               pb_in_rst,
  input  logic               req_ko,
  input  logic               req_bomb,
  input  logic [2:0]         bomb_cnt,
  input  logic               req_stat,
  input  logic [1:0]         stat_val,
  input  logic               req_score,
  input  logic [SCORE_W-1:0] score_val,
  output logic               ack_ko,
  output logic               ack_bomb,
  output logic               ack_stat,
  output logic               ack_score,
  output logic               con_out_clk_sync,
  output logic               con_out_ko,
  output logic [2:0]         con_out_bomb,
  output logic [1:0]         con_out_stat,
  output logic [SCORE_W-1:0] con_out_score,
  output logic               busy
);

  localparam int CNT_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HOLD_CYC / 2 - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lastKo_q, lastKo_d;
  logic               ackKo_q, ackKo_d;
  logic               ackBomb_q, ackBomb_d;
  logic               ackStat_q, ackStat_d;
  logic               ackScore_q, ackScore_d;
  logic               sync_q, sync_d;
  logic               ko_q, ko_d;
  logic [2:0]         bomb_q, bomb_d;
  logic [1:0]         stat_q, stat_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               busy_q, busy_d;

  // Outputs are computed one cycle ahead so the grant edge already shows the first DRIVE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lastKo_d   = lastKo_q;
    ackKo_d    = 1'b0;
    ackBomb_d  = 1'b0;
    ackStat_d  = 1'b0;
    ackScore_d = 1'b0;
    sync_d     = sync_q;
    ko_d       = ko_q;
    bomb_d     = bomb_q;
    stat_d     = stat_q;
    score_d    = score_q;

    case (state_q)
      IDLE: begin
        sync_d = 1'b0;
        if (req_ko) begin
          ackKo_d  = 1'b1;
          ko_d     = 1'b1;
          lastKo_d = 1'b1;
          cnt_d    = '0;
          state_d  = DRIVE;
        end else if (req_bomb) begin
          ackBomb_d = 1'b1;
          // An empty garbage attack is acknowledged but never put on the wire.
          if (bomb_cnt != 3'd0) begin
            bomb_d   = bomb_cnt;
            lastKo_d = 1'b0;
            cnt_d    = '0;
            state_d  = DRIVE;
          end
        end else if (req_stat) begin
          ackStat_d = 1'b1;
          stat_d    = stat_val;
          lastKo_d  = 1'b0;
          cnt_d     = '0;
          state_d   = DRIVE;
        end else if (req_score) begin
          ackScore_d = 1'b1;
          score_d    = score_val;
          lastKo_d   = 1'b0;
          cnt_d      = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = GAP;
          sync_d  = 1'b0;
          ko_d    = 1'b0;
          bomb_d  = 3'd0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          sync_d = (cnt_q >= HALF_M1);
        end
      end
      GAP: begin
        sync_d  = 1'b0;
        state_d = lastKo_q ? DONE : IDLE;
        ko_d    = lastKo_q;
      end
      DONE: begin
        sync_d = 1'b0;
        ko_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge pb_in_rst) begin
    if (!pb_in_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lastKo_q   <= 1'b0;
      ackKo_q    <= 1'b0;
      ackBomb_q  <= 1'b0;
      ackStat_q  <= 1'b0;
      ackScore_q <= 1'b0;
      sync_q     <= 1'b0;
      ko_q       <= 1'b0;
      bomb_q     <= 3'd0;
      stat_q     <= 2'd0;
      score_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lastKo_q   <= lastKo_d;
      ackKo_q    <= ackKo_d;
      ackBomb_q  <= ackBomb_d;
      ackStat_q  <= ackStat_d;
      ackScore_q <= ackScore_d;
      sync_q     <= sync_d;
      ko_q       <= ko_d;
      bomb_q     <= bomb_d;
      stat_q     <= stat_d;
      score_q    <= score_d;
      busy_q     <= busy_d;
    end
  end

  assign ack_ko           = ackKo_q;
  assign ack_bomb         = ackBomb_q;
  assign ack_stat         = ackStat_q;
  assign ack_score        = ackScore_q;
  assign con_out_clk_sync = sync_q;
  assign con_out_ko       = ko_q;
  assign con_out_bomb     = bomb_q;
  assign con_out_stat     = stat_q;
  assign con_out_score    = score_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_battle_link_ctl.sv
// Scoreboard bench for battle_link_ctl: a grant-schedule model predicts acks,
// and a negedge monitor checks each frame's shape and the idle/done values.
module tb_battle_link_ctl;

  localparam int HOLD = 4;
  localparam int SW   = 8;
  localparam int K_NONE = -1, K_KO = 0, K_BOMB = 1, K_STAT = 2, K_SCORE = 3;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } item_t;

  logic          clk = 1'b0;
  logic          pb_in_rst = 1'b1;
  logic          rKo = 1'b0, rBomb = 1'b0, rStat = 1'b0, rScore = 1'b0;
  logic [2:0]    bCnt = 3'd0;
  logic [1:0]    sVal = 2'd0;
  logic [SW-1:0] scVal = '0;
  logic          ack_ko, ack_bomb, ack_stat, ack_score;
  logic          con_out_clk_sync, con_out_ko, busy;
  logic [2:0]    con_out_bomb;
  logic [1:0]    con_out_stat;
  logic [SW-1:0] con_out_score;

  int    checks = 0, errors = 0, cyc = 0;
  item_t sbq[$];
  int    mFree = 0;
  bit    mDone = 1'b0;
  int    pendingDrop = K_NONE;
  bit    randomMode = 1'b0;

  battle_link_ctl #(.HOLD_CYC(HOLD), .SCORE_W(SW)) dut (
    .clk(clk), .pb_in_rst(pb_in_rst),
    .req_ko(rKo), .req_bomb(rBomb), .bomb_cnt(bCnt),
    .req_stat(rStat), .stat_val(sVal),
    .req_score(rScore), .score_val(scVal),
    .ack_ko(ack_ko), .ack_bomb(ack_bomb), .ack_stat(ack_stat), .ack_score(ack_score),
    .con_out_clk_sync(con_out_clk_sync), .con_out_ko(con_out_ko),
    .con_out_bomb(con_out_bomb), .con_out_stat(con_out_stat),
    .con_out_score(con_out_score), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] koBomb(input int kind, input int data);
    if (kind == K_KO) return 4'b1000;
    if (kind == K_BOMB) return {1'b0, 3'(data)};
    return 4'b0000;
  endfunction

  // Monitor: pops an expectation on each ack, then follows the frame it announced.
  int    framePos = 0, curKind = K_NONE, curData = 0;
  bit    inDone = 1'b0;
  int    expStat = 0, expScore = 0;
  item_t it;
  logic [3:0] ackVec;

  always @(negedge clk) begin
    ackVec = {ack_ko, ack_bomb, ack_stat, ack_score};
    if (!pb_in_rst) begin
      checkOutput("resetOutputs", {ackVec, con_out_clk_sync, con_out_ko, con_out_bomb,
                                   con_out_stat, con_out_score, busy}, 32'd0);
      framePos = 0;
      inDone   = 1'b0;
      expStat  = 0;
      expScore = 0;
    end else if (inDone) begin
      checkOutput("doneState", {ackVec, con_out_clk_sync, con_out_ko, con_out_bomb, busy},
                  {4'b0, 1'b0, 1'b1, 3'b0, 1'b1});
    end else if (framePos != 0) begin
      framePos++;
      if (framePos <= HOLD) begin
        checkOutput("driveAck", ackVec, 0);
        checkOutput("driveSync", con_out_clk_sync, framePos > HOLD / 2);
        checkOutput("driveField", {con_out_ko, con_out_bomb}, koBomb(curKind, curData));
        checkOutput("driveBusy", busy, 1);
      end else begin
        checkOutput("gap", {ackVec, con_out_clk_sync, con_out_ko, con_out_bomb, busy},
                    {4'b0, 1'b0, 1'b0, 3'b0, 1'b1});
        framePos = 0;
        if (curKind == K_KO) inDone = 1'b1;
      end
    end else if (ackVec != 4'b0) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpectedAck", ackVec, 0);
      end else begin
        it = sbq.pop_front();
        checkOutput("ackKind", ackVec, 4'b1000 >> it.kind);
        checkOutput("grantCycle", cyc, it.cyc);
        if (it.kind == K_STAT) expStat = it.data;
        if (it.kind == K_SCORE) expScore = it.data;
        if (it.kind == K_BOMB && it.data == 0) begin
          checkOutput("bombZero", {con_out_clk_sync, con_out_ko, con_out_bomb, busy}, 0);
        end else begin
          curKind  = it.kind;
          curData  = it.data;
          framePos = 1;
          checkOutput("firstDrive", {con_out_clk_sync, con_out_ko, con_out_bomb, busy},
                      {1'b0, koBomb(it.kind, it.data), 1'b1});
        end
      end
    end else begin
      checkOutput("idle", {con_out_clk_sync, con_out_ko, con_out_bomb, busy}, 0);
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        it = sbq.pop_front();
        checkOutput("missingAck", ackVec, 4'b1000 >> it.kind);
      end
    end
    if (pb_in_rst) begin
      checkOutput("statField", con_out_stat, expStat);
      checkOutput("scoreField", con_out_score, expScore);
    end
  end

  // Reference: the block is free to grant again HOLD+2 cycles after a frame
  // grant, one cycle after an empty bomb, and never after a KO.
  task automatic modelEdge();
    int e, k, d;
    e = cyc + 1;
    k = K_NONE;
    d = 0;
    if (!mDone && e >= mFree) begin
      if (rKo)         k = K_KO;
      else if (rBomb)  begin k = K_BOMB;  d = int'(bCnt);  end
      else if (rStat)  begin k = K_STAT;  d = int'(sVal);  end
      else if (rScore) begin k = K_SCORE; d = int'(scVal); end
    end
    if (k != K_NONE) begin
      sbq.push_back('{kind: k, data: d, cyc: e});
      pendingDrop = k;
      mFree = (k == K_BOMB && d == 0) ? e + 1 : e + HOLD + 2;
      if (k == K_KO) mDone = 1'b1;
    end
  endtask

  task automatic randomizeRequests();
    if (rKo) begin if ($urandom_range(0, 24) == 0) rKo = 1'b0; end
    else if ($urandom_range(0, 299) == 0) rKo = 1'b1;
    if (rBomb) begin if ($urandom_range(0, 24) == 0) rBomb = 1'b0; end
    else if ($urandom_range(0, 5) == 0) begin rBomb = 1'b1; bCnt = 3'($urandom_range(0, 7)); end
    if (rStat) begin if ($urandom_range(0, 24) == 0) rStat = 1'b0; end
    else if ($urandom_range(0, 5) == 0) begin rStat = 1'b1; sVal = 2'($urandom_range(0, 3)); end
    if (rScore) begin if ($urandom_range(0, 24) == 0) rScore = 1'b0; end
    else if ($urandom_range(0, 5) == 0) begin rScore = 1'b1; scVal = SW'($urandom_range(0, 255)); end
  endtask

  // One cycle of stimulus, entered and left at a falling edge.
  task automatic applyStimulus();
    case (pendingDrop)
      K_KO:    rKo = 1'b0;
      K_BOMB:  rBomb = 1'b0;
      K_STAT:  rStat = 1'b0;
      K_SCORE: rScore = 1'b0;
      default: ;
    endcase
    pendingDrop = K_NONE;
    if (randomMode) randomizeRequests();
    modelEdge();
    @(negedge clk);
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #2 pb_in_rst = 1'b0;
    #1 checkOutput("asyncReset", {ack_ko, ack_bomb, ack_stat, ack_score, con_out_clk_sync,
                                  con_out_ko, con_out_bomb, con_out_stat, con_out_score, busy}, 32'd0);
    sbq.delete();
    mFree = 0;
    mDone = 1'b0;
    pendingDrop = K_NONE;
    @(negedge clk);
    #1 pb_in_rst = 1'b1;
  endtask

  initial begin
    int doneCount;
    #1 pb_in_rst = 1'b0;
    #1 checkOutput("powerOnReset", {ack_ko, ack_bomb, ack_stat, ack_score, con_out_clk_sync,
                                    con_out_ko, con_out_bomb, con_out_stat, con_out_score, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1 pb_in_rst = 1'b1;

    rBomb = 1'b1; bCnt = 3'd3;
    repeat (9) applyStimulus();

    rScore = 1'b1; scVal = 8'h2A; rStat = 1'b1; sVal = 2'd2;
    repeat (16) applyStimulus();

    rBomb = 1'b1; bCnt = 3'd0;
    repeat (4) applyStimulus();

    rScore = 1'b1; scVal = 8'h55;
    applyStimulus();
    resetPulse();
    repeat (10) applyStimulus();

    rKo = 1'b1; rBomb = 1'b1; bCnt = 3'd5;
    repeat (14) applyStimulus();
    rBomb = 1'b0;
    resetPulse();

    randomMode = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 || doneCount > 12) begin
        resetPulse();
        doneCount = 0;
      end else begin
        applyStimulus();
        if (mDone) doneCount++;
      end
    end

    randomMode = 1'b0;
    rKo = 1'b0; rBomb = 1'b0; rStat = 1'b0; rScore = 1'b0;
    repeat (HOLD + 4) applyStimulus();
    checkOutput("queueEmpty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
